// File: rtl/spi_arb.sv
// spi_arb: shares one SPI transaction engine between the inertial interface
// (high priority) and the A2D interface (low priority). One 16-bit job at a
// time; ss_sel routes SS_n to the granted device for the whole job.
// Optional watchdog on the BUSY wait: define SPI_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no job in flight; arbitrate pending requests, latch winner's cmd
// LAUNCH | command and ss_sel stable; spi_wrt pulses for this cycle only
// BUSY   | waiting for spi_done (or watchdog expiry when enabled)
module spi_arb #(
  parameter int STARVE_MAX = 4
`ifdef SPI_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inert_req,
  input  logic [15:0] inert_cmd,
  output logic        inert_done,
  input  logic        a2d_req,
  input  logic [15:0] a2d_cmd,
  output logic        a2d_done,
  output logic [15:0] rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        ss_sel,
  output logic        busy,
  output logic        tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t      state_q, state_d;
  logic        ss_sel_q, ss_sel_d;
  logic [15:0] spi_cmd_q, spi_cmd_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        inert_done_q, inert_done_d;
  logic        a2d_done_q, a2d_done_d;
  logic        tmo_err_q, tmo_err_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic        grant_a2d;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [11:0] TMO_LOAD = 12'(TIMEOUT_CYC - 1);
  logic [11:0] wdog_q, wdog_d;
  logic        expire;
`endif

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ss_sel_q     <= 1'b0;
      spi_cmd_q    <= 16'h0000;
      rd_data_q    <= 16'h0000;
      inert_done_q <= 1'b0;
      a2d_done_q   <= 1'b0;
      tmo_err_q    <= 1'b0;
      starve_cnt_q <= 3'd0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_q       <= 12'd0;
`endif
    end else begin
      state_q      <= state_d;
      ss_sel_q     <= ss_sel_d;
      spi_cmd_q    <= spi_cmd_d;
      rd_data_q    <= rd_data_d;
      inert_done_q <= inert_done_d;
      a2d_done_q   <= a2d_done_d;
      tmo_err_q    <= tmo_err_d;
      starve_cnt_q <= starve_cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  // Next-state, arbitration, starvation counter and completion handling
  always_comb begin
    state_d      = state_q;
    ss_sel_d     = ss_sel_q;
    spi_cmd_d    = spi_cmd_q;
    rd_data_d    = rd_data_q;
    inert_done_d = 1'b0;
    a2d_done_d   = 1'b0;
    tmo_err_d    = 1'b0;
    starve_cnt_d = starve_cnt_q;
    // inertial wins ties until A2D has been passed over STARVE_MAX times
    grant_a2d    = a2d_req & (~inert_req | (starve_cnt_q == STARVE_LIM));
`ifdef SPI_ARB_TIMEOUT_EN
    wdog_d       = wdog_q;
    expire       = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!a2d_req) begin
          starve_cnt_d = 3'd0;
        end
        if (inert_req || a2d_req) begin
          state_d   = S_LAUNCH;
          ss_sel_d  = grant_a2d;
          spi_cmd_d = grant_a2d ? a2d_cmd : inert_cmd;
          if (grant_a2d) begin
            starve_cnt_d = 3'd0;
          end else if (a2d_req && (starve_cnt_q != 3'd7)) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
        wdog_d  = TMO_LOAD;
`endif
      end
      S_BUSY: begin
`ifdef SPI_ARB_TIMEOUT_EN
        expire = (wdog_q == 12'd0);
        wdog_d = wdog_q - 12'd1;
`endif
        // a real completion in the expiry cycle takes precedence
        if (spi_done) begin
          state_d      = S_IDLE;
          rd_data_d    = spi_rd_data;
          inert_done_d = ~ss_sel_q;
          a2d_done_d   = ss_sel_q;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (expire) begin
          state_d      = S_IDLE;
          rd_data_d    = 16'hFFFF;
          inert_done_d = ~ss_sel_q;
          a2d_done_d   = ss_sel_q;
          tmo_err_d    = 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and registers
  always_comb begin
    spi_wrt    = (state_q == S_LAUNCH);
    busy       = (state_q != S_IDLE);
    spi_cmd    = spi_cmd_q;
    ss_sel     = ss_sel_q;
    rd_data    = rd_data_q;
    inert_done = inert_done_q;
    a2d_done   = a2d_done_q;
    tmo_err    = tmo_err_q;
  end

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: directed bench for spi_arb with a behavioural SPI engine and a
// scoreboard of expected jobs (owner, command, response, timeout flag).
module tb_spi_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        inert_req, a2d_req;
  logic [15:0] inert_cmd, a2d_cmd;
  logic        inert_done, a2d_done;
  logic [15:0] rd_data, spi_cmd, spi_rd_data;
  logic        spi_wrt, spi_done, ss_sel, busy, tmo_err;

  always #5 clk = ~clk;

  spi_arb #(
    .STARVE_MAX(4)
`ifdef SPI_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .inert_req(inert_req), .inert_cmd(inert_cmd), .inert_done(inert_done),
    .a2d_req(a2d_req), .a2d_cmd(a2d_cmd), .a2d_done(a2d_done),
    .rd_data(rd_data), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .ss_sel(ss_sel), .busy(busy), .tmo_err(tmo_err)
  );

  typedef struct {
    logic        owner;
    logic [15:0] cmd;
    logic [15:0] rd;
    logic        tmo;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_mism = 0;
  int cyc = 0;
  int wrt_cnt = 0;
  int sd_cyc = -10;
  int stray_req = 0;
  int stray_seen = 0;
  bit model_en = 1'b1;
  bit model_fixed = 1'b0;
  int model_delay = 3;
  logic [15:0] model_data = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_jobs(input int n, input int budget, input string tag);
    int got;
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (inert_done === 1'b1) got++;
      if (a2d_done === 1'b1) got++;
    end
    chk(tag, 32'(got), 32'(n));
  endtask

  task automatic count_jobs(input int cycles, output int got);
    got = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (inert_done === 1'b1 || a2d_done === 1'b1) got++;
    end
  endtask

  // Behavioural SPI engine: answers each spi_wrt after model_delay cycles
  initial begin : spi_model
    logic [15:0] c;
    bit abort;
    spi_done = 1'b0;
    spi_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        spi_rd_data = 16'hDEAD;
        spi_done = 1'b1;
        sd_cyc = cyc;
      end else if (spi_wrt === 1'b1 && model_en && rst !== 1'b1) begin
        c = spi_cmd;
        abort = 1'b0;
        for (int i = 0; i < model_delay; i++) begin
          @(negedge clk);
          if (rst === 1'b1) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          spi_rd_data = model_fixed ? model_data : ~c;
          spi_done = 1'b1;
          sd_cyc = cyc;
        end
      end
    end
  end

  // Scoreboard monitor: launch, hold and completion checks
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) continue;
      if (spi_wrt === 1'b1) wrt_cnt++;
      if (busy === 1'b1) begin
        if (sb.size() == 0) begin
          chk("busy_unexpected", 32'(busy), 32'd0);
        end else begin
          chk("hold_cmd", 32'(spi_cmd), 32'(sb[0].cmd));
          chk("hold_sel", 32'(ss_sel), 32'(sb[0].owner));
        end
      end
      if (inert_done === 1'b1 || a2d_done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'({inert_done, a2d_done}), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_excl", 32'(inert_done & a2d_done), 32'd0);
          chk("done_owner", 32'(a2d_done), 32'(e.owner));
          chk("done_rd", 32'(rd_data), 32'(e.rd));
          chk("done_busy", 32'(busy), 32'd0);
          chk("done_tmo", 32'(tmo_err), 32'(e.tmo));
          if (!e.tmo) chk("done_lat", 32'(cyc), 32'(sd_cyc + 1));
        end
      end
    end
  end

  initial begin : guard
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int w0, got, wc;
    rst = 1'b1;
    inert_req = 1'b0;
    a2d_req = 1'b0;
    inert_cmd = 16'h0000;
    a2d_cmd = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ss_sel", 32'(ss_sel), 32'd0);
    chk("rst_spi_cmd", 32'(spi_cmd), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_spi_wrt", 32'(spi_wrt), 32'd0);
    chk("rst_dones", 32'({inert_done, a2d_done}), 32'd0);
    chk("rst_tmo", 32'(tmo_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single inertial job, 20-cycle engine latency
    model_fixed = 1'b1;
    model_data = 16'h1234;
    model_delay = 20;
    sb.push_back('{1'b0, 16'hA400, 16'h1234, 1'b0});
    w0 = wrt_cnt;
    inert_cmd = 16'hA400;
    inert_req = 1'b1;
    @(negedge clk);
    chk("t1_wrt_lat", 32'(spi_wrt), 32'd1);
    chk("t1_ss_sel", 32'(ss_sel), 32'd0);
    inert_req = 1'b0;
    wait_jobs(1, 60, "t1_jobs");
    chk("t1_rd", 32'(rd_data), 32'h1234);
    chk("t1_wrt_cnt", 32'(wrt_cnt - w0), 32'd1);
    @(negedge clk);

    // both requesters held: expect I,I,I,I,A repeating
    model_fixed = 1'b0;
    model_delay = 3;
    inert_cmd = 16'h1111;
    a2d_cmd = 16'h2222;
    for (int j = 0; j < 10; j++) begin
      logic a;
      a = (j % 5 == 4);
      sb.push_back('{a, a ? 16'h2222 : 16'h1111, a ? ~16'h2222 : ~16'h1111, 1'b0});
    end
    w0 = wrt_cnt;
    inert_req = 1'b1;
    a2d_req = 1'b1;
    wait_jobs(10, 400, "starve_jobs");
    inert_req = 1'b0;
    a2d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("starve_wrt_cnt", 32'(wrt_cnt - w0), 32'd10);
    chk("starve_sb_left", 32'(sb.size()), 32'd0);

    // one-cycle A2D request; inertial cmd changes while busy
    model_delay = 8;
    a2d_cmd = 16'h3C3C;
    sb.push_back('{1'b1, 16'h3C3C, ~16'h3C3C, 1'b0});
    a2d_req = 1'b1;
    @(negedge clk);
    a2d_req = 1'b0;
    chk("pulse_wrt", 32'(spi_wrt), 32'd1);
    chk("pulse_sel", 32'(ss_sel), 32'd1);
    chk("pulse_cmd_launch", 32'(spi_cmd), 32'h3C3C);
    @(negedge clk);
    inert_cmd = 16'hBEEF;
    wait_jobs(1, 40, "pulse_jobs");
    chk("pulse_cmd_end", 32'(spi_cmd), 32'h3C3C);
    @(negedge clk);

    // reset three cycles into BUSY of an A2D job
    model_delay = 20;
    a2d_cmd = 16'h7777;
    sb.push_back('{1'b1, 16'h7777, ~16'h7777, 1'b0});
    a2d_req = 1'b1;
    @(negedge clk);
    chk("rst_job_wrt", 32'(spi_wrt), 32'd1);
    a2d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_job_busy", 32'(busy), 32'd1);
    chk("rst_job_sel", 32'(ss_sel), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_sel", 32'(ss_sel), 32'd0);
    chk("rst_mid_dones", 32'({inert_done, a2d_done}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    count_jobs(25, got);
    chk("rst_no_done", 32'(got), 32'd0);

    // served normally after reset
    model_delay = 5;
    inert_cmd = 16'h0F0F;
    sb.push_back('{1'b0, 16'h0F0F, ~16'h0F0F, 1'b0});
    inert_req = 1'b1;
    @(negedge clk);
    chk("post_rst_wrt", 32'(spi_wrt), 32'd1);
    inert_req = 1'b0;
    wait_jobs(1, 40, "post_rst_jobs");
    chk("post_rst_rd", 32'(rd_data), 32'hF0F0);
    @(negedge clk);

    // stray spi_done while IDLE
    model_en = 1'b0;
    stray_req++;
    count_jobs(5, got);
    chk("stray_no_done", 32'(got), 32'd0);
    chk("stray_rd", 32'(rd_data), 32'hF0F0);
    chk("stray_busy", 32'(busy), 32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
    // no response: watchdog aborts after 16 BUSY cycles
    inert_cmd = 16'h4242;
    sb.push_back('{1'b0, 16'h4242, 16'hFFFF, 1'b1});
    inert_req = 1'b1;
    @(negedge clk);
    chk("tmo_wrt", 32'(spi_wrt), 32'd1);
    wc = cyc;
    inert_req = 1'b0;
    wait_jobs(1, 40, "tmo_jobs");
    chk("tmo_lat", 32'(cyc - wc), 32'd17);
    chk("tmo_rd", 32'(rd_data), 32'hFFFF);
    @(negedge clk);
    stray_req++;
    count_jobs(5, got);
    chk("tmo_stray_no_done", 32'(got), 32'd0);
`else
    wc = 0;
`endif
    model_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("final_sb_left", 32'(sb.size() + wc - wc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
